gamma_race_scheduler: RTL and testbench

Sequences gamma cycles for a bank of edge-coded (rising) temporal comparators, such as the exclusive-min less_than cells. In SETUP it drives the comparators' `set` input and the sources' clear. In RUN it time-stamps the first rising edge on each of N temporal lines. In DONE it reports the per-line spike times and the exclusive (unique) earliest line over a valid/ready handshake. It sits between the spike sources and the downstream column/WTA logic.

---
 rtl/gamma_race_scheduler.sv | 136 +++++++++++++
 tb/tb_gamma_race_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gamma_race_scheduler.sv
// Gamma-cycle sequencer for edge-coded temporal comparators: SETUP pulses set/clear,
// RUN time-stamps the first rising edge per line, DONE presents stamps and the exclusive minimum.
module gamma_race_scheduler #(
    parameter int N_LINES           = 8,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int SET_CYCLES        = 2,
    parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       continuous,
    input  logic [N_LINES-1:0]         line_in,
    output logic                       set,
    output logic                       line_clr,
    output logic                       busy,
    output logic [TW-1:0]              tick,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [N_LINES*TW-1:0]      res_time,
    output logic [N_LINES-1:0]         res_fired,
    output logic [$clog2(N_LINES)-1:0] res_min_idx,
    output logic                       res_min_valid
);
    localparam int IW  = $clog2(N_LINES);
    localparam int SCW = $clog2(SET_CYCLES + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [SCW-1:0]        set_cnt_q, set_cnt_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic                  set_q, set_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [N_LINES*TW-1:0] time_q, time_d;
    logic [N_LINES-1:0]    fired_q, fired_d;
    logic [IW-1:0]         min_idx_q, min_idx_d;
    logic                  min_valid_q, min_valid_d;
    logic                  first_q, first_d;
    logic [N_LINES-1:0]    new_mask;

    assign new_mask = line_in & ~fired_q;

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        fired_d     = fired_q;
        min_idx_d   = min_idx_q;
        min_valid_d = min_valid_q;
        first_d     = first_q;
        set_cnt_d   = (state_q == S_SETUP) ? set_cnt_q + 1'b1 : '0;

        case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: if (set_cnt_q == SCW'(SET_CYCLES - 1)) state_d = S_RUN;
            S_RUN: begin
                for (int i = 0; i < N_LINES; i++) begin
                    if (new_mask[i]) begin
                        time_d[i*TW +: TW] = tick_q;
                        fired_d[i]         = 1'b1;
                    end
                end
                // Only the first tick with any new edge decides the exclusive minimum.
                if (!first_q && (|new_mask)) begin
                    first_d     = 1'b1;
                    min_valid_d = $onehot(new_mask);
                    for (int i = N_LINES - 1; i >= 0; i--) begin
                        if (new_mask[i]) min_idx_d = IW'(i);
                    end
                end
                if (tick_q == LAST_TICK) begin
                    state_d = S_DONE;
                    // Silent lines report the last tick as "infinity".
                    for (int i = 0; i < N_LINES; i++) begin
                        if (!fired_d[i]) time_d[i*TW +: TW] = LAST_TICK;
                    end
                end
            end
            S_DONE:  if (res_ready) state_d = continuous ? S_SETUP : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SETUP) begin
            time_d      = '0;
            fired_d     = '0;
            min_idx_d   = '0;
            min_valid_d = 1'b0;
            first_d     = 1'b0;
        end

        tick_d  = (state_d == S_RUN && state_q == S_RUN) ? tick_q + 1'b1 : '0;
        set_d   = (state_d == S_SETUP);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            set_cnt_q   <= '0;
            tick_q      <= '0;
            set_q       <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            time_q      <= '0;
            fired_q     <= '0;
            min_idx_q   <= '0;
            min_valid_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            tick_q      <= tick_d;
            set_q       <= set_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            time_q      <= time_d;
            fired_q     <= fired_d;
            min_idx_q   <= min_idx_d;
            min_valid_q <= min_valid_d;
            first_q     <= first_d;
        end
    end

    assign set           = set_q;
    assign line_clr      = set_q;
    assign busy          = busy_q;
    assign tick          = tick_q;
    assign res_valid     = valid_q;
    assign res_time      = time_q;
    assign res_fired     = fired_q;
    assign res_min_idx   = min_idx_q;
    assign res_min_valid = min_valid_q;
endmodule

// File: tb/tb_gamma_race_scheduler.sv
// Directed bench for gamma_race_scheduler: line patterns are described as rise/fall ticks,
// expected results are derived from them and queued, then popped when DONE presents results.
module tb_gamma_race_scheduler;
    localparam int N  = 8;
    localparam int G  = 16;
    localparam int S  = 2;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst, start, continuous, res_ready;
    logic [N-1:0]    line_in;
    logic            set, line_clr, busy, res_valid, res_min_valid;
    logic [TW-1:0]   tick;
    logic [N*TW-1:0] res_time;
    logic [N-1:0]    res_fired;
    logic [2:0]      res_min_idx;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [N*TW-1:0] tstamp;
        logic [N-1:0]    fired;
        logic [2:0]      idx;
        logic            mvld;
    } exp_t;

    exp_t sb[$];
    int rise[N];
    int fall[N];
    int rise2[N];

    gamma_race_scheduler #(.N_LINES(N), .GAMMA_CYCLE_WIDTH(G), .SET_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .line_in(line_in),
        .set(set), .line_clr(line_clr), .busy(busy), .tick(tick), .res_valid(res_valid),
        .res_ready(res_ready), .res_time(res_time), .res_fired(res_fired),
        .res_min_idx(res_min_idx), .res_min_valid(res_min_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hi(input int i, input int t);
        return ((t >= rise[i]) && (t < fall[i])) || (t >= rise2[i]);
    endfunction

    task automatic clear_pat();
        for (int i = 0; i < N; i++) begin
            rise[i] = 99; fall[i] = 99; rise2[i] = 99;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int   first_t;
        int   earliest;
        int   cnt;
        logic [TW-1:0] st;
        e.tstamp = '0; e.fired = '0; e.idx = '0; e.mvld = 1'b0;
        earliest = 99;
        for (int i = 0; i < N; i++) begin
            first_t = -1;
            for (int t = 0; t < G; t++)
                if (hi(i, t) && first_t < 0) first_t = t;
            if (first_t >= 0) begin
                e.fired[i] = 1'b1;
                st = first_t[TW-1:0];
                if (first_t < earliest) earliest = first_t;
            end else begin
                st = TW'(G - 1);
            end
            e.tstamp[i*TW +: TW] = st;
        end
        cnt = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (e.fired[i] && e.tstamp[i*TW +: TW] == earliest[TW-1:0]) begin
                cnt++;
                e.idx = i[2:0];
            end
        end
        e.mvld = (cnt == 1);
        sb.push_back(e);
    endtask

    task automatic drive_lines(input int t);
        for (int i = 0; i < N; i++) line_in[i] = hi(i, t);
    endtask

    task automatic check_res(input string tag, input exp_t e);
        check({tag, "_time"},  res_time,      e.tstamp);
        check({tag, "_fired"}, res_fired,     e.fired);
        check({tag, "_idx"},   res_min_idx,   e.idx);
        check({tag, "_mvld"},  res_min_valid, e.mvld);
    endtask

    task automatic gamma(input string tag, input bit do_start, input bit cont, input int hold);
        int   setc = 0;
        int   runc = 0;
        exp_t e;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 200; k++) begin
            if (res_valid) break;
            if (set) begin
                setc++;
                line_in = '0;
            end else begin
                check({tag, "_tick"}, tick, runc);
                drive_lines(runc);
                runc++;
            end
            check({tag, "_busy"}, busy, 1);
            @(negedge clk);
        end
        check({tag, "_done_reached"}, res_valid, 1);
        check({tag, "_set_cycles"}, setc, S);
        check({tag, "_run_cycles"}, runc, G);
        check({tag, "_clr_eq_set"}, line_clr, set);
        e = sb.pop_front();
        check_res(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, res_valid, 1);
            check_res({tag, "_hold"}, e);
        end
        res_ready  = 1'b1;
        continuous = cont;
        @(negedge clk);
        res_ready  = 1'b0;
        continuous = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        if (cont) begin
            check({tag, "_restart_set"}, set, 1);
            check({tag, "_restart_clr_fired"}, res_fired, 0);
            check({tag, "_restart_clr_time"}, res_time, 0);
            check({tag, "_restart_clr_mvld"}, res_min_valid, 0);
        end else begin
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_idle_hold_fired"}, res_fired, e.fired);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_set"}, set, 0);
        check({tag, "_clr"}, line_clr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_time"}, res_time, 0);
        check({tag, "_fired"}, res_fired, 0);
        check({tag, "_idx"}, res_min_idx, 0);
        check({tag, "_mvld"}, res_min_valid, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; res_ready = 1'b0; line_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        clear_pat(); rise[3] = 5; rise[6] = 9;
        push_exp();
        gamma("single_min", 1, 0, 0);
        check("single_min_fired_const", res_fired, 8'b0100_1000);

        clear_pat(); rise[2] = 4; rise[5] = 4; rise[0] = 7;
        push_exp();
        gamma("tie", 1, 0, 0);

        clear_pat(); rise[1] = 0; fall[1] = 3; rise2[1] = 8;
        push_exp();
        gamma("first_edge", 1, 0, 0);

        clear_pat(); rise[7] = 15;
        push_exp();
        gamma("cont_a", 1, 1, 5);
        clear_pat(); rise[0] = 0;
        push_exp();
        gamma("cont_b", 0, 0, 0);

        clear_pat(); rise[4] = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (busy && !set) begin
                if (tick == 4'd7) break;
                drive_lines(int'(tick));
            end
            @(negedge clk);
        end
        check("midrun_tick7_reached", tick, 7);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        line_in = '0;
        @(negedge clk);
        clear_pat();
        push_exp();
        gamma("after_reset", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
